// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter, LSB first, idle-high line, with a
// small TX FIFO so the core can post several bytes ahead of the serial line.
// Optional even-parity bit between the data and stop bits: define
// UART_TX_PARITY_EN to build it (frame grows from 10 to 11 bit periods).
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         tx_byte,
    input  logic               tx_write,
    output logic               tx_full,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               tx
);

    localparam int               CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam int               NW       = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] CNT_FULL = NW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t             r_state;
    state_t             w_next_state;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_full;
    logic               r_busy;
    logic               r_tx;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;

    logic               w_term;
    logic               w_nonempty;
    logic               w_push;
    logic               w_pop;
    logic [FIFO_AW:0]   w_count_next;
    logic               w_tx_next;
    logic [CW-1:0]      w_cnt_next;
    logic [2:0]         w_idx_next;
    logic [2:0]         w_idx_inc;
    logic [7:0]         w_shift_next;

    assign w_term     = (r_cnt == CNT_MAX);
    assign w_nonempty = (r_count != '0);
    assign w_push     = tx_write && !r_full;
    assign w_idx_inc  = r_idx + 1'b1;

    assign tx         = r_tx;
    assign tx_full    = r_full;
    assign tx_busy    = r_busy;
    assign fifo_count = r_count;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: advance on bit-period terminal counts
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_nonempty) w_next_state = START;
            START: if (w_term) w_next_state = DATA;
            DATA: begin
                if (w_term && (r_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_term) w_next_state = STOP;
`endif
            STOP: begin
                if (w_term) begin
                    w_next_state = w_nonempty ? START : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Next values of the line, baud counter, bit index and FIFO pop request
    always_comb begin
        w_pop      = 1'b0;
        w_tx_next  = r_tx;
        w_cnt_next = r_cnt + 1'b1;
        w_idx_next = r_idx;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_tx_next  = 1'b1;
                if (w_nonempty) begin
                    w_pop     = 1'b1;
                    w_tx_next = 1'b0;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_term) begin
                    w_cnt_next = '0;
                    w_idx_next = '0;
                    w_tx_next  = r_shift[0];
                end
            end
            DATA: begin
                if (w_term) begin
                    w_cnt_next = '0;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_next = ^r_shift;
`else
                        w_tx_next = 1'b1;
`endif
                    end else begin
                        w_idx_next = w_idx_inc;
                        w_tx_next  = r_shift[w_idx_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_term) begin
                    w_cnt_next = '0;
                    w_tx_next  = 1'b1;
                end
            end
`endif
            STOP: begin
                w_tx_next = 1'b1;
                if (w_term) begin
                    w_cnt_next = '0;
                    if (w_nonempty) begin
                        // Chain straight into the next start bit, no idle gap
                        w_pop     = 1'b1;
                        w_tx_next = 1'b0;
                    end
                end
            end
            default: begin
                w_cnt_next = '0;
                w_idx_next = '0;
                w_tx_next  = 1'b1;
            end
        endcase
    end

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Shift register load on pop
    always_comb begin
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = r_mem[r_rd_ptr];
        end
    end

    // FIFO storage; contents need no reset since the pointers gate access
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= tx_byte;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_busy   <= 1'b0;
            r_tx     <= 1'b1;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
            r_busy  <= (w_next_state != IDLE) || (w_count_next != '0);
            r_tx    <= w_tx_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed stimulus for uart_transmitter with a frame
// decoder/scoreboard. Expected bytes are queued when written; the monitor
// decodes each frame from the tx line at mid-bit and compares.
module tb_uart_transmitter;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_CYC = 11 * CPB;
`else
    localparam int FRAME_CYC = 10 * CPB;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] tx_byte;
    logic       tx_write;
    logic       tx_full;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic       tx;

    int n_vec;
    int n_err;
    logic [7:0] sb[$];

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .FIFO_AW      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_byte    (tx_byte),
        .tx_write   (tx_write),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n, output logic ab);
        ab = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rst !== 1'b0) ab = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (tx_busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check("idle_wait", {31'd0, tx_busy}, 32'd0);
    endtask

    // Frame decoder: detect falling edge, sample each bit at its midpoint
    initial begin : monitor
        logic       prev;
        logic       ab;
        logic       a1;
        logic       st;
        logic       sp;
        logic [7:0] d;
        logic [7:0] e;
`ifdef UART_TX_PARITY_EN
        logic       pb;
        pb = 1'b0;
`endif
        prev = 1'b1;
        d    = '0;
        st   = 1'b0;
        sp   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev = 1'b1;
            end else if (tx === 1'b0 && prev === 1'b1) begin
                wait_neg(8, ab);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        wait_neg(16, a1);
                        ab   = ab | a1;
                        d[i] = tx;
                    end
                end
`ifdef UART_TX_PARITY_EN
                if (!ab) begin
                    wait_neg(16, a1);
                    ab = ab | a1;
                    pb = tx;
                end
`endif
                if (!ab) begin
                    wait_neg(16, a1);
                    ab = ab | a1;
                    sp = tx;
                end
                if (ab) begin
                    prev = 1'b1;
                end else begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got byte %0h, expected no frame (t=%0t)", d, $time);
                    end else begin
                        e = sb.pop_front();
                        check("frame_byte", {24'd0, d}, {24'd0, e});
                        check("start_bit", {31'd0, st}, 32'd0);
                        check("stop_bit", {31'd0, sp}, 32'd1);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", {31'd0, pb}, {31'd0, ^e});
`endif
                    end
                    prev = tx;
                end
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int j;
        int t;
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        tx_byte  = 8'h00;
        tx_write = 1'b0;
        tick();
        tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_full", {31'd0, tx_full}, 32'd0);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Single byte 0x55: latency, start-bit length, busy duration
        tx_byte = 8'h55; tx_write = 1'b1; sb.push_back(8'h55);
        tick();
        tx_write = 1'b0;
        check("w55_count", {29'd0, fifo_count}, 32'd1);
        check("w55_tx_idle", {31'd0, tx}, 32'd1);
        check("w55_busy", {31'd0, tx_busy}, 32'd1);
        tick();
        check("w55_latency_tx", {31'd0, tx}, 32'd0);
        check("w55_pop_count", {29'd0, fifo_count}, 32'd0);
        j = 0;
        while (tx === 1'b0 && j < 100) begin tick(); j++; end
        check("start_len", j, 32'd16);
        t = j;
        while (tx_busy === 1'b1 && t < 400) begin tick(); t++; end
        check("busy_len", t, FRAME_CYC);
        check("end_tx", {31'd0, tx}, 32'd1);
        repeat (5) tick();

        // Back-to-back frames 0xA3, 0x0F
        tx_byte = 8'hA3; tx_write = 1'b1; sb.push_back(8'hA3);
        tick();
        tx_byte = 8'h0F; sb.push_back(8'h0F);
        tick();
        tx_write = 1'b0;
        check("b2b_start", {31'd0, tx}, 32'd0);
        repeat (FRAME_CYC - 1) tick();
        check("b2b_stop_end", {31'd0, tx}, 32'd1);
        tick();
        check("b2b_no_gap", {31'd0, tx}, 32'd0);
        check("b2b_busy", {31'd0, tx_busy}, 32'd1);
        wait_idle(1000);
        repeat (5) tick();

        // Six writes from idle: fill FIFO, drop 0x06, then write during full+pop
        tx_write = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            tx_byte = 8'(b);
            if (b <= 5) sb.push_back(8'(b));
            tick();
            if (b == 5) begin
                check("fill_count", {29'd0, fifo_count}, 32'd4);
                check("fill_full", {31'd0, tx_full}, 32'd1);
            end
            if (b == 6) begin
                check("drop_count", {29'd0, fifo_count}, 32'd4);
                check("drop_full", {31'd0, tx_full}, 32'd1);
            end
        end
        tx_write = 1'b0;
        repeat (FRAME_CYC - 5) tick();
        tx_byte = 8'h77; tx_write = 1'b1;
        tick();
        tx_write = 1'b0;
        check("fullpop_count", {29'd0, fifo_count}, 32'd3);
        check("fullpop_full", {31'd0, tx_full}, 32'd0);
        check("fullpop_tx", {31'd0, tx}, 32'd0);
        wait_idle(1000);
        repeat (5) tick();

        // Reset during data bit 3 with two bytes queued
        tx_byte = 8'h3C; tx_write = 1'b1;
        tick();
        tx_byte = 8'h11;
        tick();
        tx_byte = 8'h22;
        tick();
        tx_write = 1'b0;
        check("rq_count", {29'd0, fifo_count}, 32'd2);
        repeat (69) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_full", {31'd0, tx_full}, 32'd0);
        repeat (400) tick();
        check("post_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("post_rst_tx", {31'd0, tx}, 32'd1);

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07: parity bit 1, 176-cycle frame
        tx_byte = 8'h07; tx_write = 1'b1; sb.push_back(8'h07);
        tick();
        tx_write = 1'b0;
        tick();
        check("par_start", {31'd0, tx}, 32'd0);
        repeat (152) tick();
        check("par_bit_07", {31'd0, tx}, 32'd1);
        t = 152;
        while (tx_busy === 1'b1 && t < 400) begin tick(); t++; end
        check("par_frame_len", t, 32'd176);
`endif

        repeat (20) tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
